// File: rtl/fetch_unit.sv
// fetch_unit: ARMv4 instruction fetch stage with a single outstanding imem
// request, PC register, hold buffer and the IF/ID register feeding decode.
// Ports: clk/rst (sync, active-low); imem_req/imem_addr request side;
// imem_data/imem_valid response side; stall from the hazard unit;
// SELPC/SELBRANCHDIR redirects with pc_wb_value/branch_target; IF/ID outputs
// instr/instr_valid/pc_plus8 plus decoder field slices.
// Optional FETCH_STATS_EN adds fetch_cnt/drop_cnt counters.
module fetch_unit #(
    parameter int             bus      = 32,
    parameter logic [bus-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    output logic [bus-1:0] imem_addr,
    output logic           imem_req,
    input  logic [bus-1:0] imem_data,
    input  logic           imem_valid,
    input  logic           stall,
    input  logic           SELBRANCHDIR,
    input  logic           SELPC,
    input  logic [bus-1:0] branch_target,
    input  logic [bus-1:0] pc_wb_value,
    output logic [bus-1:0] instr,
    output logic           instr_valid,
    output logic [bus-1:0] pc_plus8,
    output logic [3:0]     cond,
    output logic [1:0]     op,
    output logic [5:0]     funct,
    output logic [3:0]     rd,
    output logic [4:0]     shamt5,
    output logic [1:0]     sh,
    output logic           shift_type
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]    fetch_cnt,
    output logic [31:0]    drop_cnt
`endif
);

    typedef enum logic [1:0] {
        S_ISSUE,
        S_WAIT,
        S_DROP,
        S_HOLD
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [bus-1:0] r_pc;
    logic [bus-1:0] w_pc_nxt;
    logic [bus-1:0] r_hold;
    logic [bus-1:0] w_hold_nxt;
    logic [bus-1:0] r_instr;
    logic           r_valid;
    logic [bus-1:0] r_pc8;
    logic           w_redir;
    logic [bus-1:0] w_sel;
    logic [bus-1:0] w_target;
    logic           w_load;
    logic [bus-1:0] w_word;
    logic           w_req;

    // SELPC wins over a simultaneous branch; targets are word aligned.
    assign w_redir  = SELPC | SELBRANCHDIR;
    assign w_sel    = SELPC ? pc_wb_value : branch_target;
    assign w_target = {w_sel[bus-1:2], 2'b00};

    always_comb begin
        w_next     = r_state;
        w_pc_nxt   = r_pc;
        w_hold_nxt = r_hold;
        w_load     = 1'b0;
        w_word     = r_hold;
        w_req      = 1'b0;
        unique case (r_state)
            S_ISSUE: begin
                if (w_redir) begin
                    w_pc_nxt = w_target;
                end else begin
                    w_req  = 1'b1;
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_valid) begin
                    if (w_redir) begin
                        w_pc_nxt = w_target;
                        w_next   = S_ISSUE;
                    end else if (stall) begin
                        w_hold_nxt = imem_data;
                        w_next     = S_HOLD;
                    end else begin
                        w_load = 1'b1;
                        w_word = imem_data;
                        w_next = S_ISSUE;
                    end
                end else if (w_redir) begin
                    w_pc_nxt = w_target;
                    w_next   = S_DROP;
                end
            end
            S_DROP: begin
                if (w_redir) begin
                    w_pc_nxt = w_target;
                end
                if (imem_valid) begin
                    w_next = S_ISSUE;
                end
            end
            S_HOLD: begin
                if (w_redir) begin
                    w_pc_nxt = w_target;
                    w_next   = S_ISSUE;
                end else if (!stall) begin
                    w_load = 1'b1;
                    w_next = S_ISSUE;
                end
            end
            default: w_next = S_ISSUE;
        endcase
        if (w_load) begin
            w_pc_nxt = r_pc + bus'(4);
        end
    end

    // No request may escape while reset is being applied.
    assign imem_req  = w_req & rst;
    assign imem_addr = r_pc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_ISSUE;
            r_pc    <= RESET_PC;
            r_hold  <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_pc8   <= RESET_PC + bus'(8);
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc_nxt;
            r_hold  <= w_hold_nxt;
            // Flush beats stall; otherwise load a word or insert a bubble.
            if (w_redir) begin
                r_valid <= 1'b0;
            end else if (!stall) begin
                if (w_load) begin
                    r_instr <= w_word;
                    r_valid <= 1'b1;
                    r_pc8   <= r_pc + bus'(8);
                end else begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

`ifdef FETCH_STATS_EN
    logic w_drop;

    // Discarded response (redirected WAIT or any DROP) or discarded buffer.
    assign w_drop =
        (imem_valid && r_state == S_WAIT && w_redir) ||
        (imem_valid && r_state == S_DROP) ||
        (r_state == S_HOLD && w_redir);

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (w_load) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (w_drop) begin
                drop_cnt <= drop_cnt + 32'd1;
            end
        end
    end
`endif

    assign instr       = r_instr;
    assign instr_valid = r_valid;
    assign pc_plus8    = r_pc8;
    assign cond        = r_instr[31:28];
    assign op          = r_instr[27:26];
    assign funct       = r_instr[25:20];
    assign rd          = r_instr[15:12];
    assign shamt5      = r_instr[11:7];
    assign sh          = r_instr[6:5];
    assign shift_type  = r_instr[4];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch traffic against a transaction-level model
// of the fetch stage, plus directed redirect, stall and reset scenarios.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_data;
    logic        imem_valid;
    logic        stall;
    logic        SELBRANCHDIR;
    logic        SELPC;
    logic [31:0] branch_target;
    logic [31:0] pc_wb_value;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc_plus8;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [4:0]  shamt5;
    logic [1:0]  sh;
    logic        shift_type;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt;
    logic [31:0] drop_cnt;
`endif

    fetch_unit #(.bus(32), .RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_req     (imem_req),
        .imem_data    (imem_data),
        .imem_valid   (imem_valid),
        .stall        (stall),
        .SELBRANCHDIR (SELBRANCHDIR),
        .SELPC        (SELPC),
        .branch_target(branch_target),
        .pc_wb_value  (pc_wb_value),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc_plus8     (pc_plus8),
        .cond         (cond),
        .op           (op),
        .funct        (funct),
        .rd           (rd),
        .shamt5       (shamt5),
        .sh           (sh),
        .shift_type   (shift_type)
`ifdef FETCH_STATS_EN
        ,
        .fetch_cnt    (fetch_cnt),
        .drop_cnt     (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Memory model: one pending response delivered lat cycles after request.
    logic        mem_pend = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_dat  = '0;
    int          lat      = 1;
    logic        ovr_en   = 1'b0;
    logic [31:0] ovr_dat  = 32'hE3A01005;
    logic [31:0] last_addr = '0;

    // Reference model: outstanding/wanted request, held word, IF/ID, counters.
    logic        m_out  = 1'b0;
    logic        m_want = 1'b0;
    logic        m_held = 1'b0;
    logic [31:0] m_buf  = '0;
    logic [31:0] m_pc   = RST_PC;
    logic [31:0] m_instr = '0;
    logic        m_iv   = 1'b0;
    logic [31:0] m_p8   = RST_PC + 32'd8;
    logic [31:0] m_fc   = '0;
    logic [31:0] m_dc   = '0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic cyc(input logic st, input logic sp, input logic sb,
                       input logic [31:0] bt, input logic [31:0] pw,
                       input logic rn);
        logic        vin;
        logic [31:0] din;
        logic        redir;
        logic        exp_req;
        logic [31:0] t;
        logic [31:0] word;
        logic [31:0] pcold;
        logic        avail;
        @(negedge clk);
        vin = 1'b0;
        din = $urandom;
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                vin      = 1'b1;
                din      = mem_dat;
                mem_pend = 1'b0;
            end
        end
        rst           = rn;
        stall         = st;
        SELPC         = sp;
        SELBRANCHDIR  = sb;
        branch_target = bt;
        pc_wb_value   = pw;
        imem_valid    = vin;
        imem_data     = din;
        #1;
        redir   = rn && (sp || sb);
        exp_req = rn && !m_out && !m_held && !redir;
        chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        if (imem_req) begin
            last_addr = imem_addr;
            mem_pend  = 1'b1;
            mem_cnt   = lat;
            mem_dat   = ovr_en ? ovr_dat : memword(imem_addr);
        end
        t     = sp ? pw : bt;
        t     = t & 32'hFFFF_FFFC;
        avail = 1'b0;
        word  = '0;
        pcold = m_pc;
        if (!rn) begin
            m_out = 0; m_want = 0; m_held = 0; m_buf = '0;
            m_pc = RST_PC; m_instr = '0; m_iv = 0;
            m_p8 = RST_PC + 32'd8; m_fc = '0; m_dc = '0;
        end else begin
            if (!m_out && !m_held) begin
                if (redir) m_pc = t;
                else begin m_out = 1; m_want = 1; end
            end else if (m_out) begin
                if (vin) begin
                    m_out = 0;
                    if (m_want && !redir) begin
                        if (st) begin m_held = 1; m_buf = din; end
                        else begin avail = 1; word = din; end
                    end else m_dc++;
                end else if (redir) m_want = 0;
                if (redir) m_pc = t;
            end else begin
                if (redir) begin m_held = 0; m_pc = t; m_dc++; end
                else if (!st) begin m_held = 0; avail = 1; word = m_buf; end
            end
            if (avail) begin m_pc = pcold + 32'd4; m_fc++; end
            if (redir) m_iv = 0;
            else if (!st) begin
                if (avail) begin
                    m_instr = word; m_iv = 1; m_p8 = pcold + 32'd8;
                end else m_iv = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_iv});
        chk("instr", instr, m_instr);
        chk("pc_plus8", pc_plus8, m_p8);
        chk("cond", {28'd0, cond}, {28'd0, m_instr[31:28]});
        chk("op", {30'd0, op}, {30'd0, m_instr[27:26]});
        chk("funct", {26'd0, funct}, {26'd0, m_instr[25:20]});
        chk("rd", {28'd0, rd}, {28'd0, m_instr[15:12]});
        chk("shamt5", {27'd0, shamt5}, {27'd0, m_instr[11:7]});
        chk("sh", {30'd0, sh}, {30'd0, m_instr[6:5]});
        chk("shift_type", {31'd0, shift_type}, {31'd0, m_instr[4]});
`ifdef FETCH_STATS_EN
        chk("fetch_cnt", fetch_cnt, m_fc);
        chk("drop_cnt", drop_cnt, m_dc);
`endif
    endtask

    task automatic plain();
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    endtask

    task automatic drain();
        lat = 1;
        for (int i = 0; i < 20 && (m_out || m_held); i++) plain();
    endtask

    initial begin
        rst = 0; stall = 0; SELPC = 0; SELBRANCHDIR = 0;
        branch_target = '0; pc_wb_value = '0;
        imem_valid = 0; imem_data = '0;

        cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h40, 32'h80, 1'b0);
        chk("rst_p8", pc_plus8, RST_PC + 32'd8);

        lat = 1;
        for (int i = 0; i < 6; i++) plain();
        chk("seq_addr", last_addr, 32'd8);

        drain();
        lat = 1;
        ovr_en = 1'b1;
        plain();
        ovr_en = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        plain();
        chk("hold_instr", instr, 32'hE3A01005);
        chk("hold_rd", {28'd0, rd}, 32'd1);
        chk("hold_funct", {26'd0, funct}, 32'h3A);
        chk("hold_valid", {31'd0, instr_valid}, 32'd1);

        drain();
        lat = 3;
        plain();
        cyc(1'b0, 1'b0, 1'b1, 32'h100, 32'd0, 1'b1);
        chk("flush", {31'd0, instr_valid}, 32'd0);
        plain();
        plain();
        plain();
        chk("br_addr", last_addr, 32'h100);

        drain();
        plain();
        drain();
        cyc(1'b0, 1'b1, 1'b1, 32'h100, 32'h200, 1'b1);
        plain();
        chk("prio_addr", last_addr, 32'h200);

        drain();
        plain();
        drain();
        lat = 2;
        plain();
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        lat = 1;
        plain();
        chk("rst_addr", last_addr, RST_PC);

        for (int i = 0; i < 800; i++) begin
            lat = $urandom_range(1, 3);
            cyc(($urandom % 4) == 0, ($urandom % 14) == 0,
                ($urandom % 10) == 0, $urandom, $urandom, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
